cdb_arbiter: RTL and testbench

- Merges the adder and multiplier result broadcasts into one registered common data bus (CDB) that the RAT and reservation stations consume.
- Sits directly downstream of the two functional units.
- Each source has its own small result FIFO. A round-robin arbiter pops at most one entry per cycle onto the CDB.
- Back-pressure reaches each functional unit through a per-source ready signal.

---
 rtl/cdb_arbiter.sv | 140 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs for the adder and multiplier,
// drained round-robin onto a single registered broadcast bus.
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 3,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          add_bus_valid_output,
    input  logic [TAG_W-1:0]              add_broadcasted_tag,
    input  logic [DATA_W-1:0]             add_broadcasted_value,
    output logic                          add_ready,
    input  logic                          mul_bus_valid_output,
    input  logic [TAG_W-1:0]              mul_broadcasted_tag,
    input  logic [DATA_W-1:0]             mul_broadcasted_value,
    output logic                          mul_ready,
    output logic                          bus_valid_output,
    output logic [TAG_W-1:0]              broadcasted_tag,
    output logic [DATA_W-1:0]             broadcasted_value,
    output logic                          broadcast_source,
    output logic [$clog2(FIFO_DEPTH):0]   add_count,
    output logic [$clog2(FIFO_DEPTH):0]   mul_count,
    output logic                          overflow_error
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_W + DATA_W;

    // Index 0 is the adder, index 1 the multiplier, matching broadcast_source.
    logic             in_valid [2];
    logic [ENT_W-1:0] in_entry [2];
    logic [ENT_W-1:0] head     [2];
    logic [CNT_W-1:0] count    [2];
    logic             ready    [2];
    logic             nonempty [2];

    logic grant_valid;
    logic grant_src;
    logic last_grant_reg;
    logic bus_valid_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [DATA_W-1:0] value_reg;
    logic source_reg;
    logic overflow_reg;

    assign in_valid[0] = add_bus_valid_output;
    assign in_valid[1] = mul_bus_valid_output;
    assign in_entry[0] = {add_broadcasted_tag, add_broadcasted_value};
    assign in_entry[1] = {mul_broadcasted_tag, mul_broadcasted_value};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic             push;
            logic             pop;

            // Ready comes from the pre-edge count, so a full FIFO never accepts
            // a push even when it is being popped on the same edge.
            assign ready[gi]    = (count_reg != CNT_W'(FIFO_DEPTH));
            assign nonempty[gi] = (count_reg != '0);
            assign push         = in_valid[gi] && ready[gi];
            assign pop          = grant_valid && (grant_src == 1'(gi));
            assign head[gi]     = mem[rd_ptr_reg];
            assign count[gi]    = count_reg;

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= in_entry[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    if (push && !pop) begin
                        count_reg <= count_reg + 1'b1;
                    end else if (!push && pop) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // On a tie the source that did not win last time gets the bus.
    always_comb begin
        grant_valid = nonempty[0] || nonempty[1];
        grant_src   = 1'b0;
        if (nonempty[0] && nonempty[1]) begin
            grant_src = ~last_grant_reg;
        end else if (nonempty[1]) begin
            grant_src = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            bus_valid_reg  <= 1'b0;
            tag_reg        <= '0;
            value_reg      <= '0;
            source_reg     <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            bus_valid_reg <= grant_valid;
            if (grant_valid) begin
                {tag_reg, value_reg} <= head[grant_src];
                source_reg           <= grant_src;
                last_grant_reg       <= grant_src;
            end
            if ((in_valid[0] && !ready[0]) || (in_valid[1] && !ready[1])) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign add_ready         = ready[0];
    assign mul_ready         = ready[1];
    assign add_count         = count[0];
    assign mul_count         = count[1];
    assign bus_valid_output  = bus_valid_reg;
    assign broadcasted_tag   = tag_reg;
    assign broadcasted_value = value_reg;
    assign broadcast_source  = source_reg;
    assign overflow_error    = overflow_reg;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// against a queue-based model of the two FIFOs and round-robin bus.
module tb_cdb_arbiter;
    localparam int DEPTH = 4;
    localparam int TW    = 3;
    localparam int DW    = 32;
    localparam int EW    = TW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          add_bus_valid_output = 1'b0;
    logic [TW-1:0] add_broadcasted_tag = '0;
    logic [DW-1:0] add_broadcasted_value = '0;
    logic          add_ready;
    logic          mul_bus_valid_output = 1'b0;
    logic [TW-1:0] mul_broadcasted_tag = '0;
    logic [DW-1:0] mul_broadcasted_value = '0;
    logic          mul_ready;
    logic          bus_valid_output;
    logic [TW-1:0] broadcasted_tag;
    logic [DW-1:0] broadcasted_value;
    logic          broadcast_source;
    logic [2:0]    add_count;
    logic [2:0]    mul_count;
    logic          overflow_error;

    cdb_arbiter #(.FIFO_DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .add_bus_valid_output(add_bus_valid_output),
        .add_broadcasted_tag(add_broadcasted_tag),
        .add_broadcasted_value(add_broadcasted_value),
        .add_ready(add_ready),
        .mul_bus_valid_output(mul_bus_valid_output),
        .mul_broadcasted_tag(mul_broadcasted_tag),
        .mul_broadcasted_value(mul_broadcasted_value),
        .mul_ready(mul_ready),
        .bus_valid_output(bus_valid_output),
        .broadcasted_tag(broadcasted_tag),
        .broadcasted_value(broadcasted_value),
        .broadcast_source(broadcast_source),
        .add_count(add_count),
        .mul_count(mul_count),
        .overflow_error(overflow_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per source, plus the expected bus register.
    logic [EW-1:0] aq[$];
    logic [EW-1:0] mq[$];
    bit            m_last;
    bit            m_valid;
    bit            m_src;
    bit            m_ovf;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_value;

    task automatic model_reset();
        aq.delete();
        mq.delete();
        m_last  = 1'b1;
        m_valid = 1'b0;
        m_src   = 1'b0;
        m_ovf   = 1'b0;
        m_tag   = '0;
        m_value = '0;
    endtask

    task automatic model_edge();
        bit a_ne, m_ne, a_rdy, m_rdy, g_src;
        logic [EW-1:0] e;
        a_ne  = aq.size() != 0;
        m_ne  = mq.size() != 0;
        a_rdy = aq.size() < DEPTH;
        m_rdy = mq.size() < DEPTH;
        if (a_ne && m_ne) g_src = !m_last;
        else              g_src = m_ne;
        m_valid = a_ne || m_ne;
        if (m_valid) begin
            if (g_src) e = mq.pop_front();
            else       e = aq.pop_front();
            m_tag   = e[EW-1:DW];
            m_value = e[DW-1:0];
            m_src   = g_src;
            m_last  = g_src;
        end
        if (add_bus_valid_output) begin
            if (a_rdy) aq.push_back({add_broadcasted_tag, add_broadcasted_value});
            else       m_ovf = 1'b1;
        end
        if (mul_bus_valid_output) begin
            if (m_rdy) mq.push_back({mul_broadcasted_tag, mul_broadcasted_value});
            else       m_ovf = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, clock them in, advance the model, then sample 1 unit later.
    task automatic step(input bit av, input logic [TW-1:0] at, input logic [DW-1:0] avl,
                        input bit mv, input logic [TW-1:0] mt, input logic [DW-1:0] mvl);
        add_bus_valid_output  = av;
        add_broadcasted_tag   = at;
        add_broadcasted_value = avl;
        mul_bus_valid_output  = mv;
        mul_broadcasted_tag   = mt;
        mul_broadcasted_value = mvl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        add_bus_valid_output = 1'b0;
        mul_bus_valid_output = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #12;
        total++; if (bus_valid_output !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", bus_valid_output); end
        total++; if (broadcasted_tag !== '0) begin bad++; $display("FAIL reset_tag got=%0h want=0", broadcasted_tag); end
        total++; if (broadcasted_value !== '0) begin bad++; $display("FAIL reset_value got=%0h want=0", broadcasted_value); end
        total++; if (broadcast_source !== 1'b0) begin bad++; $display("FAIL reset_source got=%0h want=0", broadcast_source); end
        total++; if (add_count !== 3'd0 || mul_count !== 3'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", add_count, mul_count); end
        total++; if (add_ready !== 1'b1 || mul_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b/%0b want=1/1", add_ready, mul_ready); end
        total++; if (overflow_error !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow_error); end
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        step(1, 3'd3, 32'h10, 0, 0, 0);
        total++; if (add_count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", add_count); end
        total++; if (bus_valid_output !== 1'b0) begin bad++; $display("FAIL single_early got=%0b want=0", bus_valid_output); end
        step(0, 0, 0, 0, 0, 0);
        total++; if ({bus_valid_output, broadcast_source, broadcasted_tag, broadcasted_value} !== {1'b1, 1'b0, 3'd3, 32'h10}) begin
            bad++; $display("FAIL single_bus got=v%0b s%0b t%0d %0h want=v1 s0 t3 10", bus_valid_output, broadcast_source, broadcasted_tag, broadcasted_value); end
        total++; if (add_count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", add_count); end
        step(0, 0, 0, 0, 0, 0);
        total++; if (bus_valid_output !== 1'b0 || broadcasted_tag !== 3'd3) begin
            bad++; $display("FAIL single_idle got=v%0b t%0d want=v0 t3", bus_valid_output, broadcasted_tag); end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        bit es;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 3) step(1, 3'd1, 32'hA, 1, 3'd2, 32'hB);
            else       step(0, 0, 0, 0, 0, 0);
            if (i >= 1 && i <= 6) begin
                es = ((i - 1) % 2) == 1;
                total++;
                if ({bus_valid_output, broadcast_source, broadcasted_tag, broadcasted_value} !==
                    {1'b1, es, es ? 3'd2 : 3'd1, es ? 32'hB : 32'hA}) begin
                    bad++; $display("FAIL rr_cycle%0d got=v%0b s%0b t%0d %0h want=v1 s%0b", i, bus_valid_output, broadcast_source, broadcasted_tag, broadcasted_value, es);
                end
            end else if (i == 7) begin
                total++; if (bus_valid_output !== 1'b0) begin bad++; $display("FAIL rr_idle got=%0b want=0", bus_valid_output); end
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_full_overflow();
        bit reached;
        do_reset();
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step(1, 3'd0, 32'h100 + i, 1, 3'(4 + (i % 4)), 32'(i));
            if (mq.size() == DEPTH) reached = 1;
        end
        total++; if (!reached) begin bad++; $display("FAIL full_timeout got=%0d want=%0d", mq.size(), DEPTH); end
        total++; if (mul_count !== 3'd4 || mul_ready !== 1'b0) begin bad++; $display("FAIL full_state got=c%0d r%0b want=c4 r0", mul_count, mul_ready); end
        total++; if (overflow_error !== 1'b0) begin bad++; $display("FAIL full_noovf got=%0b want=0", overflow_error); end
        step(0, 0, 0, 1, 3'd3, 32'hDEAD);
        total++; if (overflow_error !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", overflow_error); end
        total++; if (mul_count !== 3'(mq.size())) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", mul_count, mq.size()); end
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0, 0, 0, 0);
            total++;
            if (bus_valid_output !== m_valid || broadcasted_tag !== m_tag || broadcasted_value !== m_value || broadcast_source !== m_src) begin
                bad++; $display("FAIL ovf_drain%0d got=v%0b s%0b t%0d %0h want=v%0b s%0b t%0d %0h", i, bus_valid_output, broadcast_source, broadcasted_tag, broadcasted_value, m_valid, m_src, m_tag, m_value);
            end
            total++; if (bus_valid_output && broadcasted_value === 32'hDEAD) begin bad++; $display("FAIL ovf_dropped_seen got=%0h want=not dead", broadcasted_value); end
        end
        total++; if (overflow_error !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b want=1", overflow_error); end
        $display("test_full_overflow done");
    endtask

    task automatic test_wrap();
        int exp_idx;
        logic [TW-1:0] exp_tag;
        do_reset();
        exp_idx = 0;
        for (int i = 0; i < 13; i++) begin
            step(i < 10, 3'(i % 8), 32'(i), 0, 0, 0);
            total++; if (add_count > 3'd2) begin bad++; $display("FAIL wrap_count got=%0d want<=2", add_count); end
            if (bus_valid_output) begin
                exp_tag = 3'(exp_idx % 8);
                total++;
                if (broadcast_source !== 1'b0 || broadcasted_value !== 32'(exp_idx) || broadcasted_tag !== exp_tag) begin
                    bad++; $display("FAIL wrap_item got=s%0b t%0d v%0d want=s0 t%0d v%0d", broadcast_source, broadcasted_tag, broadcasted_value, exp_tag, exp_idx);
                end
                exp_idx++;
            end
        end
        total++; if (exp_idx != 10) begin bad++; $display("FAIL wrap_total got=%0d want=10", exp_idx); end
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        bit reached;
        do_reset();
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step(1, 3'd5, 32'h5500_0000 + i, 1, 3'd6, 32'h6600_0000 + i);
            if (aq.size() == 3 && m_valid) reached = 1;
        end
        total++; if (!reached || add_count !== 3'd3 || bus_valid_output !== 1'b1) begin
            bad++; $display("FAIL rstmid_setup got=c%0d v%0b want=c3 v1", add_count, bus_valid_output); end
        add_bus_valid_output = 1'b0;
        mul_bus_valid_output = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus_valid_output !== 1'b0 || broadcasted_tag !== '0 || broadcasted_value !== '0 || broadcast_source !== 1'b0 ||
            add_count !== 3'd0 || mul_count !== 3'd0 || add_ready !== 1'b1 || mul_ready !== 1'b1 || overflow_error !== 1'b0) begin
            bad++; $display("FAIL rstmid_immediate got=v%0b t%0d %0h s%0b c%0d/%0d want=all reset", bus_valid_output, broadcasted_tag, broadcasted_value, broadcast_source, add_count, mul_count);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0);
            total++; if (bus_valid_output !== 1'b0) begin bad++; $display("FAIL rstmid_stale%0d got=%0h want=none", i, broadcasted_value); end
        end
        step(1, 3'd2, 32'h77, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        total++; if (bus_valid_output !== 1'b1 || broadcasted_value !== 32'h77 || broadcasted_tag !== 3'd2) begin
            bad++; $display("FAIL rstmid_fresh got=v%0b t%0d %0h want=v1 t2 77", bus_valid_output, broadcasted_tag, broadcasted_value); end
        $display("test_reset_mid done");
    endtask

    task automatic test_push_pop_same_edge();
        bit reached;
        do_reset();
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step(1, 3'(i), 32'h200 + i, 1, 3'(i), 32'h300 + i);
            if (aq.size() == DEPTH - 1 && m_last) reached = 1;
        end
        total++; if (!reached || add_count !== 3'd3 || add_ready !== 1'b1) begin
            bad++; $display("FAIL pp_setup got=c%0d r%0b want=c3 r1", add_count, add_ready); end
        step(1, 3'd7, 32'hAB, 0, 0, 0);
        total++; if (add_count !== 3'd3 || add_ready !== 1'b1 || broadcast_source !== 1'b0) begin
            bad++; $display("FAIL pp_same_edge got=c%0d r%0b s%0b want=c3 r1 s0", add_count, add_ready, broadcast_source); end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0);
            total++;
            if (bus_valid_output !== m_valid || broadcasted_tag !== m_tag || broadcasted_value !== m_value || broadcast_source !== m_src) begin
                bad++; $display("FAIL pp_drain%0d got=v%0b s%0b t%0d %0h want=v%0b s%0b t%0d %0h", i, bus_valid_output, broadcast_source, broadcasted_tag, broadcasted_value, m_valid, m_src, m_tag, m_value);
            end
        end
        total++; if (add_count !== 3'd0 || mul_count !== 3'd0) begin bad++; $display("FAIL pp_empty got=%0d/%0d want=0/0", add_count, mul_count); end
        $display("test_push_pop_same_edge done");
    endtask

    task automatic test_random();
        int rbad;
        do_reset();
        rbad = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, 3'($urandom), $urandom,
                 $urandom_range(0, 99) < 55, 3'($urandom), $urandom);
            total++;
            if (bus_valid_output !== m_valid || broadcasted_tag !== m_tag || broadcasted_value !== m_value || broadcast_source !== m_src) begin
                bad++; rbad++;
                if (rbad < 10) $display("FAIL rand_bus%0d got=v%0b s%0b t%0d %0h want=v%0b s%0b t%0d %0h", i, bus_valid_output, broadcast_source, broadcasted_tag, broadcasted_value, m_valid, m_src, m_tag, m_value);
            end
            total++;
            if (add_count !== 3'(aq.size()) || mul_count !== 3'(mq.size()) || add_ready !== (aq.size() < DEPTH) ||
                mul_ready !== (mq.size() < DEPTH) || overflow_error !== m_ovf) begin
                bad++; rbad++;
                if (rbad < 10) $display("FAIL rand_state%0d got=c%0d/%0d r%0b%0b o%0b want=c%0d/%0d o%0b", i, add_count, mul_count, add_ready, mul_ready, overflow_error, aq.size(), mq.size(), m_ovf);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_full_overflow();
        test_wrap();
        test_reset_mid();
        test_push_pop_same_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
